crash_ctrl: RTL and testbench

Collision and life-management stage that sits directly downstream of the enemy movers. It consumes their 12-bit sprite coordinates together with the player position and detects bounding-box overlap. It produces the `CRASH` level that the enemy movers take as input: while `CRASH` is high they freeze and re-spawn. It also counts remaining lives and flags game-over.

---
 rtl/game_pkg.sv | 22 ++
 rtl/box_overlap.sv | 33 +++
 rtl/crash_ctrl.sv | 106 ++++++++++
 tb/tb_crash_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants, sprite geometry and the crash controller state type.
package game_pkg;

   localparam int COORD_W  = 12;

   localparam int ENEMY_W  = 40;
   localparam int ENEMY_H  = 40;
   localparam int PLAYER_W = 60;
   localparam int PLAYER_H = 40;

   localparam int SCREEN_W = 1280;
   localparam int SCREEN_H = 720;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLAY,
      ST_HIT,
      ST_INVULN,
      ST_OVER
   } crash_state_t;

endpackage

// File: rtl/box_overlap.sv
// Combinational bounding-box overlap between box A and box B (top-left coords).
// Box edges that only touch do not count as an overlap.
module box_overlap
   import game_pkg::*;
#(
   parameter int A_W = ENEMY_W,
   parameter int A_H = ENEMY_H,
   parameter int B_W = PLAYER_W,
   parameter int B_H = PLAYER_H
) (
   input  logic [COORD_W-1:0] a_x,
   input  logic [COORD_W-1:0] a_y,
   input  logic [COORD_W-1:0] b_x,
   input  logic [COORD_W-1:0] b_y,
   output logic               overlap
);

   // One extra bit so that coordinate + size can never wrap near the top of the range
   localparam int EXT_W = COORD_W + 1;

   logic [EXT_W-1:0] ax, ay, bx, by;

   assign ax = {1'b0, a_x};
   assign ay = {1'b0, a_y};
   assign bx = {1'b0, b_x};
   assign by = {1'b0, b_y};

   assign overlap = (ax < bx + EXT_W'(B_W)) &&
                    (bx < ax + EXT_W'(A_W)) &&
                    (ay < by + EXT_W'(B_H)) &&
                    (by < ay + EXT_W'(A_H));

endmodule

// File: rtl/crash_ctrl.sv
// Player/enemy collision detection, CRASH pulse generation, lives and game-over tracking.
module crash_ctrl #(
   parameter int ENEMY_W       = game_pkg::ENEMY_W,
   parameter int ENEMY_H       = game_pkg::ENEMY_H,
   parameter int PLAYER_W      = game_pkg::PLAYER_W,
   parameter int PLAYER_H      = game_pkg::PLAYER_H,
   parameter int LIVES         = 3,
   parameter int HIT_CYCLES    = 50_000_000,
   parameter int INVULN_CYCLES = 100_000_000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [game_pkg::COORD_W-1:0]  enemy_x,
   input  logic [game_pkg::COORD_W-1:0]  enemy_y,
   input  logic [game_pkg::COORD_W-1:0]  player_x,
   input  logic [game_pkg::COORD_W-1:0]  player_y,
   output logic                          CRASH,
   output logic [2:0]                    lives,
   output logic                          game_over,
   output logic [7:0]                    hit_count
);

   import game_pkg::*;

   crash_state_t state;
   logic         ovl;
   logic         ovl_q;
   logic [31:0]  cnt;

   box_overlap #(
      .A_W(ENEMY_W),
      .A_H(ENEMY_H),
      .B_W(PLAYER_W),
      .B_H(PLAYER_H)
   ) u_overlap (
      .a_x    (enemy_x),
      .a_y    (enemy_y),
      .b_x    (player_x),
      .b_y    (player_y),
      .overlap(ovl)
   );

   // Overlap is only acted on in PLAY, so a hit in HIT/INVULN never decrements lives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         ovl_q     <= 1'b0;
         cnt       <= '0;
         CRASH     <= 1'b1;
         game_over <= 1'b0;
         lives     <= 3'(LIVES);
         hit_count <= '0;
      end else begin
         ovl_q <= ovl;
         case (state)
            ST_IDLE, ST_OVER: begin
               if (start) begin
                  state     <= ST_PLAY;
                  CRASH     <= 1'b0;
                  game_over <= 1'b0;
                  lives     <= 3'(LIVES);
                  hit_count <= '0;
               end
            end
            ST_PLAY: begin
               if (ovl_q) begin
                  state <= ST_HIT;
                  CRASH <= 1'b1;
                  lives <= lives - 3'd1;
                  cnt   <= 32'(HIT_CYCLES - 1);
                  if (hit_count != 8'hFF) begin
                     hit_count <= hit_count + 8'd1;
                  end
               end
            end
            ST_HIT: begin
               if (cnt == '0) begin
                  if (lives == 3'd0) begin
                     state     <= ST_OVER;
                     game_over <= 1'b1;
                  end else begin
                     state <= ST_INVULN;
                     CRASH <= 1'b0;
                     cnt   <= 32'(INVULN_CYCLES - 1);
                  end
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            ST_INVULN: begin
               if (cnt == '0) begin
                  state <= ST_PLAY;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               CRASH <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crash_ctrl.sv
// Scoreboard bench for crash_ctrl: a timeline-based game model predicts outputs after every edge.
module tb_crash_ctrl;

   localparam int HIT    = 4;
   localparam int INV    = 8;
   localparam int NLIVES = 2;
   localparam int EW     = 40;
   localparam int EH     = 40;
   localparam int PW     = 60;
   localparam int PH     = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] enemy_x, enemy_y, player_x, player_y;
   logic        CRASH;
   logic [2:0]  lives;
   logic        game_over;
   logic [7:0]  hit_count;

   always #5 clk = ~clk;

   crash_ctrl #(
      .ENEMY_W      (EW),
      .ENEMY_H      (EH),
      .PLAYER_W     (PW),
      .PLAYER_H     (PH),
      .LIVES        (NLIVES),
      .HIT_CYCLES   (HIT),
      .INVULN_CYCLES(INV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .enemy_x  (enemy_x),
      .enemy_y  (enemy_y),
      .player_x (player_x),
      .player_y (player_y),
      .CRASH    (CRASH),
      .lives    (lives),
      .game_over(game_over),
      .hit_count(hit_count)
   );

   typedef struct {
      logic       crash;
      logic       go;
      logic [2:0] lv;
      logic [7:0] hc;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   function automatic void check_output(string name, int act, int req);
      total++;
      if (act == req) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
   endfunction

   // Game timeline model: edge numbers at which the crash pulse and the immunity end
   int cyc;
   bit m_in_game, m_over, m_ovl_d;
   int m_crash_end, m_imm_end, m_lives, m_hits;

   function automatic void model_reset();
      m_in_game   = 1'b0;
      m_over      = 1'b0;
      m_ovl_d     = 1'b0;
      m_crash_end = -1;
      m_imm_end   = -1;
      m_lives     = NLIVES;
      m_hits      = 0;
   endfunction

   function automatic bit ref_overlap(int ex, int ey, int px, int py);
      int lo_x, hi_x, lo_y, hi_y;
      lo_x = (ex > px) ? ex : px;
      hi_x = (ex + EW < px + PW) ? ex + EW : px + PW;
      lo_y = (ey > py) ? ey : py;
      hi_y = (ey + EH < py + PH) ? ey + EH : py + PH;
      return (lo_x < hi_x) && (lo_y < hi_y);
   endfunction

   function automatic void model_step(bit s, bit ovl_now);
      cyc++;
      if (!m_in_game) begin
         if (s) begin
            m_in_game   = 1'b1;
            m_over      = 1'b0;
            m_lives     = NLIVES;
            m_hits      = 0;
            m_crash_end = cyc;
            m_imm_end   = cyc;
         end
      end else if (cyc < m_crash_end) begin
      end else if (cyc == m_crash_end) begin
         if (m_lives == 0) begin
            m_in_game = 1'b0;
            m_over    = 1'b1;
         end
      end else if (cyc <= m_imm_end) begin
      end else if (m_ovl_d) begin
         m_lives--;
         if (m_hits < 255) m_hits++;
         m_crash_end = cyc + HIT;
         m_imm_end   = cyc + HIT + INV;
      end
      m_ovl_d = ovl_now;
   endfunction

   task automatic apply_stimulus(bit s, int ex, int ey, int px, int py);
      exp_t e;
      @(negedge clk);
      #1;
      start    = s;
      enemy_x  = 12'(ex);
      enemy_y  = 12'(ey);
      player_x = 12'(px);
      player_y = 12'(py);
      @(posedge clk);
      model_step(s, ref_overlap(ex, ey, px, py));
      e.crash = !m_in_game || (cyc < m_crash_end);
      e.go    = m_over;
      e.lv    = 3'(m_lives);
      e.hc    = 8'(m_hits);
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && sb.size() > 0) begin
         e = sb.pop_front();
         check_output("crash",     int'(CRASH),     int'(e.crash));
         check_output("game_over", int'(game_over), int'(e.go));
         check_output("lives",     int'(lives),     int'(e.lv));
         check_output("hit_count", int'(hit_count), int'(e.hc));
      end
   end

   initial begin
      int ex, ey, px, py;
      cyc      = 0;
      rst      = 1'b1;
      start    = 1'b0;
      enemy_x  = 12'd100;
      enemy_y  = 12'd100;
      player_x = 12'd600;
      player_y = 12'd600;
      model_reset();
      #12;
      check_output("rst_crash",     int'(CRASH),     1);
      check_output("rst_lives",     int'(lives),     NLIVES);
      check_output("rst_game_over", int'(game_over), 0);
      check_output("rst_hit_count", int'(hit_count), 0);
      @(negedge clk);
      rst = 1'b0;

      apply_stimulus(1'b0, 100, 100, 600, 600);
      apply_stimulus(1'b1, 100, 100, 600, 600);
      // Edge-touching player must not register a hit
      for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 100, 100, 40, 100);
      // Overlap held through both hits, invulnerability and into game over
      for (int i = 0; i < 30; i++) apply_stimulus(1'b0, 100, 100, 41, 100);
      apply_stimulus(1'b0, 100, 100, 600, 600);
      apply_stimulus(1'b1, 100, 100, 600, 600);
      apply_stimulus(1'b0, 100, 100, 600, 600);

      // Near the top of the coordinate range sums must not wrap
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 4090, 200, 4000, 200);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 4090, 200, 4040, 200);

      // Asynchronous reset while CRASH is high, between clock edges
      #3;
      rst = 1'b1;
      #1;
      check_output("async_crash",     int'(CRASH),     1);
      check_output("async_lives",     int'(lives),     NLIVES);
      check_output("async_game_over", int'(game_over), 0);
      check_output("async_hit_count", int'(hit_count), 0);
      check_output("async_state",     int'(dut.state), int'(game_pkg::ST_IDLE));
      sb.delete();
      model_reset();
      @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;

      apply_stimulus(1'b1, 100, 100, 600, 600);
      for (int i = 0; i < 600; i++) begin
         ex = 2000 + int'($urandom_range(0, 20));
         ey = 300;
         px = ex + int'($urandom_range(0, 160)) - 90;
         py = ey + int'($urandom_range(0, 100)) - 60;
         apply_stimulus(($urandom_range(0, 15) == 0), ex, ey, px, py);
      end

      @(negedge clk);
      #2;
      check_output("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
